// File: rtl/mat_accum_pkg.sv
// Shared types and helpers for the mat_accum requester arbiter.
package mat_accum_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Requester index width, never narrower than one bit.
    function automatic int req_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mat_arb_owner_fifo.sv
// In-order record of which requester owns each job still in flight in mat_accum.
module mat_arb_owner_fifo
    import mat_accum_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 1,
    localparam int PTR_W = (DEPTH <= 2) ? 1 : $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_push_data,
    input  logic         i_pop,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_head
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign o_full  = (count_q == CNT_W'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_head  = mem_q[rd_ptr_q];
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= i_push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mat_accum_arb.sv
// Packet-level round-robin arbiter sharing one mat_accum between NUM_REQ requesters,
// with in-order routing of result packets back to the job owner.
//   state   | meaning
//   ST_IDLE | no job open; pick next requester (1 cycle), no data moves
//   ST_BUSY | job open for gnt_q; stream passes through until last beat
module mat_accum_arb
    import mat_accum_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ*DATA_W-1:0] s_axis_data,
    input  logic [NUM_REQ-1:0]        s_axis_valid,
    input  logic [NUM_REQ-1:0]        s_axis_last,
    output logic [NUM_REQ-1:0]        s_axis_ready,
    output logic [DATA_W-1:0]         m_axis_data,
    output logic                      m_axis_valid,
    output logic                      m_axis_last,
    input  logic                      m_axis_ready,
    input  logic [DATA_W-1:0]         s_res_data,
    input  logic                      s_res_valid,
    input  logic                      s_res_last,
    output logic                      s_res_ready,
    output logic [DATA_W-1:0]         m_res_data,
    output logic                      m_res_last,
    output logic [NUM_REQ-1:0]        m_res_valid,
    input  logic [NUM_REQ-1:0]        m_res_ready,
    output logic                      o_busy
);

    localparam int IDX_W = req_idx_w(NUM_REQ);

    arb_state_t        state_q;
    logic [IDX_W-1:0]  gnt_q;
    logic [IDX_W-1:0]  rr_ptr_q;
    logic [DATA_W-1:0] req_data [NUM_REQ];
    logic              sel_found;
    logic [IDX_W-1:0]  sel_idx;
    logic [IDX_W-1:0]  cand_idx;
    logic              grant;
    logic              job_done;
    logic              fifo_full;
    logic              fifo_empty;
    logic [IDX_W-1:0]  fifo_head;
    logic              res_pop;

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            req_data[k] = s_axis_data[k*DATA_W +: DATA_W];
        end
    end

    // First valid requester after the last winner wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand_idx  = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand_idx = IDX_W'((int'(rr_ptr_q) + off) % NUM_REQ);
            if (!sel_found && s_axis_valid[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    assign grant    = (state_q == ST_IDLE) && sel_found && !fifo_full;
    assign job_done = m_axis_valid && m_axis_ready && m_axis_last;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant) begin
                        gnt_q    <= sel_idx;
                        rr_ptr_q <= sel_idx;
                        state_q  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (job_done) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_busy       = (state_q == ST_BUSY);
    assign m_axis_data  = req_data[gnt_q];
    assign m_axis_valid = o_busy && s_axis_valid[gnt_q];
    assign m_axis_last  = s_axis_last[gnt_q];

    always_comb begin
        s_axis_ready = '0;
        if (o_busy) begin
            s_axis_ready[gnt_q] = m_axis_ready;
        end
    end

    mat_arb_owner_fifo #(
        .DEPTH (DEPTH),
        .W     (IDX_W)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (grant),
        .i_push_data (sel_idx),
        .i_pop       (res_pop),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty),
        .o_head      (fifo_head)
    );

    // Results with no recorded owner stall rather than being dropped.
    always_comb begin
        m_res_valid = '0;
        s_res_ready = 1'b0;
        if (!fifo_empty) begin
            m_res_valid[fifo_head] = s_res_valid;
            s_res_ready            = m_res_ready[fifo_head];
        end
    end

    assign res_pop    = s_res_valid && s_res_ready && s_res_last;
    assign m_res_data = s_res_data;
    assign m_res_last = s_res_last;

endmodule

// File: tb/tb_mat_accum_arb.sv
// Self-checking bench for mat_accum_arb: requester drivers with a per-requester
// scoreboard on the mat_accum side, plus a table of result-routing vectors.
module tb_mat_accum_arb;

    localparam int NR    = 2;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR*DW-1:0] s_axis_data;
    logic [NR-1:0]    s_axis_valid;
    logic [NR-1:0]    s_axis_last;
    logic [NR-1:0]    s_axis_ready;
    logic [DW-1:0]    m_axis_data;
    logic             m_axis_valid;
    logic             m_axis_last;
    logic             m_axis_ready;
    logic [DW-1:0]    s_res_data;
    logic             s_res_valid;
    logic             s_res_last;
    logic             s_res_ready;
    logic [DW-1:0]    m_res_data;
    logic             m_res_last;
    logic [NR-1:0]    m_res_valid;
    logic [NR-1:0]    m_res_ready;
    logic             o_busy;

    always #5 clk = ~clk;

    mat_accum_arb #(.NUM_REQ(NR), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .s_axis_data  (s_axis_data),
        .s_axis_valid (s_axis_valid),
        .s_axis_last  (s_axis_last),
        .s_axis_ready (s_axis_ready),
        .m_axis_data  (m_axis_data),
        .m_axis_valid (m_axis_valid),
        .m_axis_last  (m_axis_last),
        .m_axis_ready (m_axis_ready),
        .s_res_data   (s_res_data),
        .s_res_valid  (s_res_valid),
        .s_res_last   (s_res_last),
        .s_res_ready  (s_res_ready),
        .m_res_data   (m_res_data),
        .m_res_last   (m_res_last),
        .m_res_valid  (m_res_valid),
        .m_res_ready  (m_res_ready),
        .o_busy       (o_busy)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
        logic       last;
        logic [1:0] mrr;
        logic [1:0] exp_mv;
        logic       exp_sr;
        logic       exp_busy;
    } res_vec_t;

    res_vec_t   tbl [12];
    int         errors = 0;
    int         checks = 0;
    logic [8:0] rq0 [$];
    logic [8:0] rq1 [$];
    logic [8:0] ex0 [$];
    logic [8:0] ex1 [$];
    int         gnt_log [$];
    bit         toggle_mode = 1'b0;
    bit         gap_en = 1'b0;
    bit         in_job = 1'b0;
    int         job_req = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_job(input int req, input logic [7:0] d0, input int n);
        for (int i = 0; i < n; i++) begin
            logic [8:0] b;
            b = {(i == n - 1), d0 + 8'(i)};
            if (req == 0) begin rq0.push_back(b); ex0.push_back(b); end
            else          begin rq1.push_back(b); ex1.push_back(b); end
        end
    endtask

    task automatic clear_q();
        rq0.delete(); rq1.delete(); ex0.delete(); ex1.delete(); gnt_log.delete();
    endtask

    task automatic rst_pulse();
        @(posedge clk); #2;
        rst = 1'b1;
        clear_q();
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while ((rq0.size() > 0 || rq1.size() > 0 || ex0.size() > 0 || ex1.size() > 0 || o_busy)
               && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", 32'(n < maxc), 1);
    endtask

    // Requester drivers, mat_accum-side ready and beat scoreboard.
    initial begin
        bit         f0, f1;
        int         r;
        logic [8:0] e;
        s_axis_valid = '0;
        s_axis_last  = '0;
        s_axis_data  = '0;
        m_axis_ready = 1'b1;
        forever begin
            @(negedge clk);
            f0 = !rst && s_axis_valid[0] && s_axis_ready[0];
            f1 = !rst && s_axis_valid[1] && s_axis_ready[1];
            if (rst) begin
                in_job = 1'b0;
            end else if (m_axis_valid && m_axis_ready) begin
                r = s_axis_ready[1] ? 1 : 0;
                chk("ready_onehot", 32'($countones(s_axis_ready)), 1);
                if (in_job) chk("grant_held", r, job_req);
                else begin
                    gnt_log.push_back(r);
                    job_req = r;
                    in_job  = 1'b1;
                end
                if (r == 0 && ex0.size() == 0) chk("unexpected_beat0", 1, 0);
                else if (r == 1 && ex1.size() == 0) chk("unexpected_beat1", 1, 0);
                else begin
                    e = (r == 0) ? ex0.pop_front() : ex1.pop_front();
                    chk("beat", {m_axis_last, m_axis_data}, e);
                end
                if (m_axis_last) in_job = 1'b0;
            end
            @(posedge clk); #1;
            if (f0 && rq0.size() > 0) rq0.delete(0);
            if (f1 && rq1.size() > 0) rq1.delete(0);
            s_axis_valid[0] = rq0.size() > 0 && !(gap_en && $urandom_range(0, 3) == 0);
            s_axis_valid[1] = rq1.size() > 0 && !(gap_en && $urandom_range(0, 3) == 0);
            {s_axis_last[0], s_axis_data[7:0]}  = (rq0.size() > 0) ? rq0[0] : 9'h0;
            {s_axis_last[1], s_axis_data[15:8]} = (rq1.size() > 0) ? rq1[0] : 9'h0;
            m_axis_ready = toggle_mode ? ~m_axis_ready : 1'b1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen, idle, n, head;
        rst = 1'b1;
        s_res_data  = 8'h00;
        s_res_valid = 1'b1;
        s_res_last  = 1'b0;
        m_res_ready = 2'b11;

        tbl[0]  = '{8'hA1, 1'b1, 1'b0, 2'b11, 2'b01, 1'b1, 1'b0};
        tbl[1]  = '{8'hA2, 1'b1, 1'b1, 2'b10, 2'b01, 1'b0, 1'b0};
        tbl[2]  = '{8'hA2, 1'b1, 1'b1, 2'b01, 2'b01, 1'b1, 1'b0};
        tbl[3]  = '{8'hB1, 1'b0, 1'b0, 2'b11, 2'b00, 1'b1, 1'b0};
        tbl[4]  = '{8'hB1, 1'b1, 1'b0, 2'b10, 2'b10, 1'b1, 1'b1};
        tbl[5]  = '{8'hB2, 1'b1, 1'b1, 2'b10, 2'b10, 1'b1, 1'b1};
        tbl[6]  = '{8'hC1, 1'b1, 1'b1, 2'b10, 2'b01, 1'b0, 1'b0};
        tbl[7]  = '{8'hC1, 1'b1, 1'b1, 2'b01, 2'b01, 1'b1, 1'b0};
        tbl[8]  = '{8'hD1, 1'b1, 1'b1, 2'b01, 2'b10, 1'b0, 1'b0};
        tbl[9]  = '{8'hD1, 1'b1, 1'b1, 2'b10, 2'b10, 1'b1, 1'b0};
        tbl[10] = '{8'hE1, 1'b1, 1'b1, 2'b11, 2'b01, 1'b1, 1'b0};
        tbl[11] = '{8'hF1, 1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_m_axis_valid", m_axis_valid, 0);
        chk("rst_s_axis_ready", s_axis_ready, 0);
        chk("rst_s_res_ready", s_res_ready, 0);
        chk("rst_m_res_valid", m_res_valid, 0);
        @(posedge clk); #2;
        s_res_valid = 1'b0;
        m_res_ready = 2'b00;
        rst = 1'b0;

        // Single 3-beat job from requester 0
        push_job(0, 8'h10, 1);
        rq0.delete(); ex0.delete();
        rq0.push_back(9'h010); rq0.push_back(9'h020); rq0.push_back(9'h130);
        ex0.push_back(9'h010); ex0.push_back(9'h020); ex0.push_back(9'h130);
        @(posedge clk); #2;
        @(negedge clk);
        chk("t1_arb_busy", o_busy, 0);
        chk("t1_arb_valid", m_axis_valid, 0);
        @(negedge clk);
        chk("t1_first_busy", o_busy, 1);
        chk("t1_first_valid", m_axis_valid, 1);
        chk("t1_first_data", m_axis_data, 8'h10);
        repeat (3) @(negedge clk);
        chk("t1_busy_drop", o_busy, 0);
        chk("t1_fifo_count", 32'(dut.u_fifo.count_q), 1);
        m_res_ready = 2'b11;
        #1;
        chk("t1_s_res_ready", s_res_ready, 1);
        m_res_ready = 2'b00;

        // Reset in the middle of a job with a non-empty owner FIFO
        push_job(1, 8'h81, 3);
        n = 0;
        while (!o_busy && n < 10) begin @(negedge clk); n++; end
        chk("t4_grant_seen", 32'(n < 10), 1);
        @(posedge clk); #2;
        rst = 1'b1;
        clear_q();
        s_res_valid = 1'b1;
        m_res_ready = 2'b11;
        @(negedge clk);
        chk("t4_busy_before_rst", o_busy, 1);
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk("t4_rst_busy", o_busy, 0);
        chk("t4_rst_m_axis_valid", m_axis_valid, 0);
        chk("t4_rst_s_axis_ready", s_axis_ready, 0);
        chk("t4_rst_s_res_ready", s_res_ready, 0);
        chk("t4_rst_m_res_valid", m_res_valid, 0);
        s_res_valid = 1'b0;
        m_res_ready = 2'b00;
        push_job(0, 8'h91, 1);
        push_job(1, 8'h92, 1);
        drain(100);
        chk("t4_njobs", gnt_log.size(), 2);
        if (gnt_log.size() == 2) begin
            chk("t4_first_gnt", gnt_log[0], 0);
            chk("t4_second_gnt", gnt_log[1], 1);
        end

        // Continuous contention, 2-beat jobs, alternating grants
        rst_pulse();
        push_job(0, 8'h10, 1); rq0.delete(); ex0.delete();
        for (int j = 0; j < 2; j++) begin
            rq0.push_back(9'h010); rq0.push_back(9'h120);
            ex0.push_back(9'h010); ex0.push_back(9'h120);
            rq1.push_back(9'h030); rq1.push_back(9'h140);
            ex1.push_back(9'h030); ex1.push_back(9'h140);
        end
        seen = 0; idle = 0; n = 0;
        while ((rq0.size() > 0 || rq1.size() > 0 || ex0.size() > 0 || ex1.size() > 0 || o_busy)
               && n < 200) begin
            @(negedge clk);
            n++;
            if (o_busy) begin
                if (seen != 0 && idle > 0) chk("t2_idle_gap", idle, 1);
                seen = 1;
                idle = 0;
            end else if (seen != 0) begin
                idle++;
            end
        end
        chk("t2_drain", 32'(n < 200), 1);
        chk("t2_njobs", gnt_log.size(), 4);
        for (int i = 0; i < gnt_log.size(); i++) chk("t2_order", gnt_log[i], i % 2);

        // Owner FIFO full: fifth job must wait
        push_job(0, 8'h50, 2);
        repeat (4) @(negedge clk);
        chk("full_no_grant", o_busy, 0);
        chk("full_m_axis_valid", m_axis_valid, 0);
        chk("full_count", 32'(dut.u_fifo.count_q), DEPTH);

        // Result routing vectors
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #2;
            s_res_data  = tbl[i].data;
            s_res_valid = tbl[i].valid;
            s_res_last  = tbl[i].last;
            m_res_ready = tbl[i].mrr;
            @(negedge clk);
            chk("res_m_res_valid", m_res_valid, tbl[i].exp_mv);
            chk("res_s_res_ready", s_res_ready, tbl[i].exp_sr);
            chk("res_m_res_data", m_res_data, tbl[i].data);
            chk("res_busy", o_busy, tbl[i].exp_busy);
        end
        s_res_valid = 1'b0;
        m_res_ready = 2'b00;
        drain(50);

        // Backpressure on m_axis_ready plus requester valid gaps
        rst_pulse();
        toggle_mode = 1'b1;
        gap_en = 1'b1;
        push_job(0, 8'h01, 3);
        push_job(1, 8'h11, 3);
        push_job(0, 8'h04, 3);
        push_job(1, 8'h14, 3);
        drain(600);
        chk("t3_njobs", gnt_log.size(), 4);
        toggle_mode = 1'b0;
        gap_en = 1'b0;
        head = (gnt_log.size() > 0) ? gnt_log[0] : 0;
        @(posedge clk); #2;
        m_res_ready = (head == 0) ? 2'b10 : 2'b01;
        s_res_data  = 8'hEE;
        s_res_valid = 1'b1;
        s_res_last  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t3_s_res_ready_hold", s_res_ready, 0);
            chk("t3_m_res_valid_head", m_res_valid, (head == 0) ? 2'b01 : 2'b10);
        end
        s_res_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mat_accum_arb.md
Name: mat_accum_arb

Overview:
- Packet-level round-robin arbiter that shares one mat_accum instance between NUM_REQ matrix-stream requesters.
- Grants the mat_accum input stream to one requester per job. A job is one packet terminated by last.
- Records the owner of each job in an in-order owner FIFO.
- Routes each returning result packet (m_axis_res_*) back to the requester that issued the job.
- Sits directly between requester front-ends and mat_accum.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_W, 8, stream data width; matches mat_accum.
- DEPTH, 4, max jobs in flight (granted, result not yet fully returned); power of 2.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- s_axis_data  in  NUM_REQ*DATA_W  requester input data; requester k occupies bits [k*DATA_W +: DATA_W].
- s_axis_valid  in  NUM_REQ  per-requester valid.
- s_axis_last  in  NUM_REQ  per-requester end of job.
- s_axis_ready  out  NUM_REQ  per-requester ready.
- m_axis_data  out  DATA_W  to mat_accum s_axis_data.
- m_axis_valid  out  1  to mat_accum s_axis_valid.
- m_axis_last  out  1  to mat_accum s_axis_last.
- m_axis_ready  in  1  from mat_accum s_axis_ready.
- s_res_data  in  DATA_W  from mat_accum m_axis_res_data.
- s_res_valid  in  1  from mat_accum m_axis_res_valid.
- s_res_last  in  1  from mat_accum m_axis_res_last.
- s_res_ready  out  1  to mat_accum m_axis_res_ready.
- m_res_data  out  DATA_W  result data, shared by all requesters.
- m_res_last  out  1  result end of packet, shared.
- m_res_valid  out  NUM_REQ  per-requester result valid.
- m_res_ready  in  NUM_REQ  per-requester result ready.
- o_busy  out  1  high in BUSY state.

Behaviour:
- Handshake: a beat transfers when valid && ready on the same edge. Valid must not depend on ready.

Arbiter FSM, states IDLE and BUSY:
- IDLE:
  - If any s_axis_valid is high and the owner FIFO is not full, select the first valid requester searching from (rr_ptr+1) mod NUM_REQ upward.
  - On the selection: latch gnt, set rr_ptr <= gnt, push gnt into the owner FIFO, go to BUSY.
  - No data passes in IDLE. Arbitration costs exactly 1 cycle per job.
- BUSY:
  - Zero-latency combinational pass-through: m_axis_data/valid/last = requester gnt's signals; s_axis_ready[gnt] = m_axis_ready.
  - All other s_axis_ready bits are 0.
  - Return to IDLE on the edge where the granted beat with last=1 transfers.
- Outputs when not BUSY: m_axis_valid = 0, all s_axis_ready = 0.
- Grant is held through m_axis_ready backpressure and through requester valid gaps. Other requesters never preempt a job.

Round-robin:
- rr_ptr resets to NUM_REQ-1, so requester 0 wins the first contention.
- When both requesters continuously request, grants alternate 0,1,0,1.

Owner FIFO:
- DEPTH entries of clog2(NUM_REQ) bits, plus a count of 0..DEPTH.
- Push on grant; pop when a result beat with s_res_last=1 transfers.
- Push and pop on the same edge: count unchanged, both pointers advance.
- When full (count==DEPTH), no grant is issued. The current job in BUSY still completes.

Result routing:
- When the FIFO is empty: s_res_ready = 0 and all m_res_valid = 0. Orphan results stall and are never dropped.
- Otherwise, with head = owner at the FIFO head:
  - m_res_valid[head] = s_res_valid; all other m_res_valid bits are 0.
  - s_res_ready = m_res_ready[head].
  - m_res_data and m_res_last pass through combinationally.
- Result routing runs concurrently with and independently of input arbitration.

Reset:
- While i_rst is high at an edge: state = IDLE, FIFO emptied, rr_ptr = NUM_REQ-1.
- Resulting outputs: m_axis_valid = 0, s_axis_ready = 0, s_res_ready = 0, m_res_valid = 0, o_busy = 0.
- Reset mid-job aborts the job; no partial-packet recovery. mat_accum must be reset together with this block.

Widths: no arithmetic on data. rr_ptr and gnt are clog2(NUM_REQ) bits, with at least 1 bit. Pointer wrap is modulo DEPTH.

Decomposition:
- Package mat_accum_pkg holds:
  - DATA_W default.
  - The FSM state encoding (ST_IDLE=0, ST_BUSY=1).
  - A requester-index width function.
- One sub-module, mat_arb_owner_fifo. It is a synchronous FIFO with push/pop/full/empty/head and reset via i_rst.

Test Plan:
- Reset, then requester 0 sends 0x10, 0x20, 0x30 (last on 0x30):
  - m_axis shows those beats, starting one cycle after valid is seen in IDLE.
  - o_busy drops after 0x30.
  - FIFO count = 1.
- Both requesters valid continuously with 2-beat jobs (req0 0x10, 0x20; req1 0x30, 0x40):
  - Jobs appear in order req0, req1, req0, req1.
  - Each job is separated by one IDLE cycle.
- Results for that traffic, 2 beats each (0xA1, 0xA2 last, then 0xB1, 0xB2 last):
  - m_res_valid[0] is asserted for the A beats only, then m_res_valid[1] for the B beats only.
- Backpressure: toggle m_axis_ready every cycle and drop requester valid mid-job:
  - No beat is lost or duplicated.
  - Grant never changes before last.
  - With m_res_ready[head] = 0, s_res_ready stays 0.
- DEPTH=2, three requester jobs, no results returned:
  - Third grant is withheld (o_busy stays 0).
  - Returning one result packet with last lets the third job be granted on the following cycle.
- Assert i_rst for one cycle in the middle of a BUSY job with a non-empty FIFO:
  - The next cycle shows all outputs at reset values.
  - The next contention grants requester 0 first.
